// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its mul/div busy tracker.
// Pure declarations: no latency or backpressure of its own.
package hazard_pkg;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MD_BUSY = 1'b1
   } md_state_e;

   localparam int REG_ZERO = 0;
   localparam int STAT_W   = 16;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Mul/div occupancy FSM: busy for MD_LATENCY cycles after an accepted start; last flags the final busy cycle.
// Start acceptance takes effect on the next clock edge; starts presented while busy are ignored.
module md_busy_tracker
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 32,
   parameter int MD_CNT_W   = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic start_ok,
   output logic busy,
   output logic last
);

   md_state_e           state, state_nxt;
   logic [MD_CNT_W-1:0] mdcnt, mdcnt_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_RUN;
         mdcnt <= '0;
      end else begin
         state <= state_nxt;
         mdcnt <= mdcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      mdcnt_nxt = mdcnt;
      case (state)
         ST_RUN: begin
            if (start_ok) begin
               state_nxt = ST_MD_BUSY;
               mdcnt_nxt = MD_CNT_W'(MD_LATENCY - 1);
            end
         end
         ST_MD_BUSY: begin
            if (mdcnt == '0) begin
               state_nxt = ST_RUN;
            end else begin
               mdcnt_nxt = mdcnt - 1'b1;
            end
         end
         default: begin
            state_nxt = ST_RUN;
            mdcnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      busy = (state == ST_MD_BUSY);
      last = busy && (mdcnt == '0);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use and mul/div stalls, branch/jump flush; zero-latency combinational controls.
// Stall holds IF/ID and PC and bubbles ID/EX; optional HAZARD_STATS_EN builds saturating stall/flush counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int MD_LATENCY = 32,
   parameter int MD_CNT_W   = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              id_branch_taken,
   input  logic              id_jump,
   input  logic              id_md_start,
   input  logic              id_md_read,
   output logic              ifid_stall,
   output logic              ifid_flush,
   output logic              pc_write,
   output logic              idex_bubble,
   output logic              md_busy,
   output logic [STAT_W-1:0] stat_stalls,
   output logic [STAT_W-1:0] stat_flushes
);

   logic load_use;
   logic md_hz;
   logic stall;
   logic redirect;
   logic start_ok;
   logic md_busy_w;
   logic md_last;

   md_busy_tracker #(
      .MD_LATENCY (MD_LATENCY),
      .MD_CNT_W   (MD_CNT_W)
   ) u_md_busy_tracker (
      .clk      (clk),
      .reset    (reset),
      .start_ok (start_ok),
      .busy     (md_busy_w),
      .last     (md_last)
   );

   // last is a subset of busy; named here so the final busy cycle visibly still stalls
   always_comb begin
      load_use = ex_mem_read && (ex_rt != REG_AW'(REG_ZERO)) &&
                 ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
      md_hz    = (md_busy_w || md_last) && (id_md_read || id_md_start);
      stall    = load_use || md_hz;
      redirect = (id_branch_taken || id_jump) && !stall;
      start_ok = id_md_start && !stall;
   end

   always_comb begin
      if (!reset) begin
         ifid_stall  = 1'b0;
         ifid_flush  = 1'b1;
         pc_write    = 1'b0;
         idex_bubble = 1'b1;
      end else begin
         ifid_stall  = stall;
         ifid_flush  = redirect;
         pc_write    = !stall;
         idex_bubble = stall;
      end
      md_busy = md_busy_w;
   end

`ifdef HAZARD_STATS_EN
   logic [STAT_W-1:0] stalls_q;
   logic [STAT_W-1:0] flushes_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stalls_q  <= '0;
         flushes_q <= '0;
      end else begin
         if (stall) begin
            stalls_q <= sat_inc(stalls_q);
         end
         if (redirect) begin
            flushes_q <= sat_inc(flushes_q);
         end
      end
   end

   assign stat_stalls  = stalls_q;
   assign stat_flushes = flushes_q;
`else
   assign stat_stalls  = '0;
   assign stat_flushes = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that sequences the IF/ID register, PC and ID/EX register.
- Drives the stall and flush controls of the IF/ID register, the PC write enable and the ID/EX bubble insert.
- Tracks a multi-cycle mul/div unit with an internal busy counter and FSM.
- Sits beside the ID stage; all decisions are made from ID-stage and EX-stage fields in the same cycle.

Parameters:
- REG_AW, 5, register address width.
- MD_LATENCY, 32, cycles the mul/div unit stays busy after a start (legal range 1..63).
- MD_CNT_W, 6, width of the busy counter; must satisfy 2^MD_CNT_W > MD_LATENCY.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  REG_AW  rs field of the instruction in ID.
- id_rt  in  REG_AW  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  REG_AW  destination of the load in EX.
- id_branch_taken  in  1  branch resolved taken in ID.
- id_jump  in  1  jump in ID.
- id_md_start  in  1  ID instruction is mult/div.
- id_md_read  in  1  ID instruction is mfhi/mflo.
- ifid_stall  out  1  hold the IF/ID register.
- ifid_flush  out  1  clear the IF/ID instruction.
- pc_write  out  1  PC update enable.
- idex_bubble  out  1  zero the ID/EX control fields.
- md_busy  out  1  mul/div unit occupied.
- stat_stalls  out  16  stall-cycle count (optional feature).
- stat_flushes  out  16  flush count (optional feature).

Behaviour:
- FSM states: RUN and MD_BUSY. Reset state is RUN, mdcnt=0.
- While reset is low: ifid_stall=0, ifid_flush=1, pc_write=0, idex_bubble=1, md_busy=0, both stat counters=0. Release takes effect asynchronously into RUN.
- load_use = ex_mem_read && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
- md_hz = (state==MD_BUSY) && (id_md_read || id_md_start).
- stall = load_use || md_hz. Outputs are combinational, zero-latency:
  - ifid_stall=stall
  - pc_write=!stall
  - idex_bubble=stall
- ifid_flush = (id_branch_taken || id_jump) && !stall. Stall has priority; a stalled branch flushes in the cycle it is released.
- A load-use stall lasts exactly 1 cycle, because the load advances out of EX.
- RUN -> MD_BUSY on id_md_start && !stall; mdcnt <= MD_LATENCY-1.
- In MD_BUSY:
  - mdcnt decrements each cycle.
  - When mdcnt==0 the next state is RUN.
  - md_busy=1 for the whole of MD_BUSY.
- An id_md_read or id_md_start arriving in the last busy cycle (mdcnt==0) is still stalled; it is released the following cycle.
- A start is never accepted in MD_BUSY.
- A start blocked by load_use in RUN is not accepted that cycle.
- Independent instructions proceed during MD_BUSY. Branches and jumps still flush normally.
- MD_LATENCY=1: exactly one MD_BUSY cycle.
- reset asserted mid-MD_BUSY: immediately RUN, mdcnt=0, md_busy=0.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stat_stalls increments on every cycle with stall=1.
  - stat_flushes increments on every cycle with ifid_flush=1.
  - Both are 16-bit, saturating at 0xFFFF, and cleared by reset.
- Undefined: both ports are still present and tied to 0; no counter logic is built.

Decomposition:
- Shared package hazard_pkg holds:
  - the FSM state enum (ST_RUN, ST_MD_BUSY);
  - REG_ZERO constant (0);
  - STAT_W=16.
- One natural sub-module, md_busy_tracker, containing the FSM and mdcnt. It takes start_ok and outputs busy and last.
- Hazard equations and the stat counters stay in hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> one cycle of ifid_stall=1, pc_write=0, idex_bubble=1. Next cycle with ex_mem_read=0 -> stall=0.
- ex_rt=0 with matching rs=0 -> no stall.
- Branch and hazard together: id_branch_taken=1 with load_use -> cycle 1 ifid_flush=0 and stall=1; cycle 2 ifid_flush=1 and stall=0.
- Mul/div, MD_LATENCY=4: id_md_start accepted at cycle 0 -> md_busy=1 for cycles 1-4.
  - id_md_read held from cycle 2 stalls cycles 2-4 and releases at cycle 5.
  - An independent ALU op at cycle 2 is not stalled.
- Reset mid-operation: reset low at cycle 2 of MD_BUSY -> outputs go to reset values immediately. After release, md_busy=0 and id_md_read is not stalled.
- HAZARD_STATS_EN: 3 load-use stalls plus 2 jumps -> stat_stalls=3, stat_flushes=2. Forcing stall for 70000 cycles -> stat_stalls=0xFFFF.
